// File: rtl/quadgen_pkg.sv
// Shared types and constants for the quadrature generator.
// Holds the FSM state enum, the A/B phase patterns for both
// rotation directions and the idle output level.
package quadgen_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PH1  = 3'd1,
    PH2  = 3'd2,
    PH3  = 3'd3,
    PH4  = 3'd4
  } qg_state_t;

  // Both channels high while no detent is being emitted.
  localparam logic [1:0] IDLE_AB = 2'b11;

  // Packed {PH4, PH3, PH2, PH1}; each entry is {A, B}.
  // Clockwise: B is still high when A falls.
  localparam logic [7:0] UP_PHASES   = {2'b11, 2'b10, 2'b00, 2'b01};
  // Counter-clockwise: B is already low when A falls.
  localparam logic [7:0] DOWN_PHASES = {2'b11, 2'b01, 2'b00, 2'b10};

  // A/B levels for a given phase and direction.
  function automatic logic [1:0] phase_ab(input logic down, input qg_state_t st);
    logic [7:0] pat;
    logic [1:0] ab;
    pat = down ? DOWN_PHASES : UP_PHASES;
    case (st)
      PH1:     ab = pat[1:0];
      PH2:     ab = pat[3:2];
      PH3:     ab = pat[5:4];
      PH4:     ab = pat[7:6];
      default: ab = IDLE_AB;
    endcase
    return ab;
  endfunction

  // Phase that follows PH1..PH3; PH4 is handled by the caller.
  function automatic qg_state_t next_phase(input qg_state_t st);
    qg_state_t nx;
    case (st)
      PH1:     nx = PH2;
      PH2:     nx = PH3;
      PH3:     nx = PH4;
      default: nx = IDLE;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/quadgen_switch.sv
// Push-switch press timer for the quadrature generator.
// A press is captured on one edge and the active-low line is driven
// low on the next edge for exactly PRESS_CYCLES cycles. Presses that
// arrive while a press is armed or in progress are ignored.
module quadgen_switch #(
  parameter int PRESS_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic press,
  output logic sw
);

  localparam int CNT_W = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESS_CYCLES - 1);

  logic             sw_r;
  logic             armed_r;
  logic [CNT_W-1:0] cnt_r;

  // Capture a press, then hold the line low for the programmed length.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_r    <= 1'b1;
      armed_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (armed_r) begin
      sw_r    <= 1'b0;
      armed_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (!sw_r) begin
      if (cnt_r == CNT_LAST) begin
        sw_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if (press) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= 1'b0;
    end
  end

  assign sw = sw_r;

endmodule

// File: rtl/quadrature_generator.sv
// Rotary-encoder emulator: turns single-cycle up/down step requests
// into A/B quadrature detents, queued in a signed saturating counter.
// Optional push-switch output is enabled with QUADGEN_SWITCH_EN;
// without it sw is tied high and press is ignored.
module quadrature_generator
  import quadgen_pkg::*;
#(
  parameter int DWELL        = 4,
  parameter int PEND_W       = 4,
  parameter int PRESS_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic step_up,
  input  logic step_down,
  input  logic press,
  output logic a,
  output logic b,
  output logic sw,
  output logic busy,
  output logic overflow
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic signed [PEND_W:0] PEND_MAX = (PEND_W + 1)'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [PEND_W:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [PEND_W:0] ONE_X    = (PEND_W + 1)'(1);
  localparam logic [PEND_W-1:0]      PEND_ZERO = {PEND_W{1'b0}};

  qg_state_t                state_r;
  logic                     down_r;
  logic [1:0]               ab_r;
  logic [CNT_W-1:0]         dwell_r;
  logic signed [PEND_W-1:0] pending_r;
  logic                     busy_r;
  logic                     overflow_r;

  logic                     dwell_done_s;
  logic                     new_down_s;
  logic                     start_step_s;
  logic signed [PEND_W:0]   pend_ext_s;
  logic signed [PEND_W:0]   pend_base_s;
  logic signed [PEND_W:0]   pend_trial_s;
  logic signed [PEND_W-1:0] pending_next_s;
  logic                     overflow_s;

  // Step start, consume and saturating pending-counter update.
  always_comb begin
    dwell_done_s = (dwell_r == DWELL_LAST);
    new_down_s   = pending_r[PEND_W-1];
    pend_ext_s   = {pending_r[PEND_W-1], pending_r};

    if (state_r == IDLE) begin
      start_step_s = (pending_r != PEND_ZERO);
    end else if ((state_r == PH4) && dwell_done_s) begin
      start_step_s = (pending_r != PEND_ZERO);
    end else begin
      start_step_s = 1'b0;
    end

    // A starting step consumes one unit toward zero.
    if (start_step_s) begin
      if (new_down_s) begin
        pend_base_s = pend_ext_s + ONE_X;
      end else begin
        pend_base_s = pend_ext_s - ONE_X;
      end
    end else begin
      pend_base_s = pend_ext_s;
    end

    // Simultaneous up and down cancel without touching the counter.
    if (step_up && !step_down) begin
      pend_trial_s = pend_base_s + ONE_X;
    end else if (step_down && !step_up) begin
      pend_trial_s = pend_base_s - ONE_X;
    end else begin
      pend_trial_s = pend_base_s;
    end

    if ((pend_trial_s > PEND_MAX) || (pend_trial_s < PEND_MIN)) begin
      overflow_s     = 1'b1;
      pending_next_s = pend_base_s[PEND_W-1:0];
    end else begin
      overflow_s     = 1'b0;
      pending_next_s = pend_trial_s[PEND_W-1:0];
    end
  end

  // Phase FSM with dwell timing, registered A/B, busy and overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      down_r     <= 1'b0;
      ab_r       <= IDLE_AB;
      dwell_r    <= {CNT_W{1'b0}};
      pending_r  <= PEND_ZERO;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      pending_r  <= pending_next_s;
      overflow_r <= overflow_s;
      case (state_r)
        IDLE: begin
          if (start_step_s) begin
            state_r <= PH1;
            down_r  <= new_down_s;
            ab_r    <= phase_ab(new_down_s, PH1);
            dwell_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= (pending_next_s != PEND_ZERO);
          end
        end
        PH1, PH2, PH3: begin
          busy_r <= 1'b1;
          if (dwell_done_s) begin
            state_r <= next_phase(state_r);
            ab_r    <= phase_ab(down_r, next_phase(state_r));
            dwell_r <= {CNT_W{1'b0}};
          end else begin
            dwell_r <= dwell_r + CNT_W'(1);
          end
        end
        PH4: begin
          if (dwell_done_s) begin
            dwell_r <= {CNT_W{1'b0}};
            if (start_step_s) begin
              // Back-to-back detent: direction re-latched, no idle gap.
              state_r <= PH1;
              down_r  <= new_down_s;
              ab_r    <= phase_ab(new_down_s, PH1);
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              ab_r    <= IDLE_AB;
              busy_r  <= (pending_next_s != PEND_ZERO);
            end
          end else begin
            dwell_r <= dwell_r + CNT_W'(1);
            busy_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          ab_r    <= IDLE_AB;
          dwell_r <= {CNT_W{1'b0}};
          busy_r  <= (pending_next_s != PEND_ZERO);
        end
      endcase
    end
  end

  assign a        = ab_r[1];
  assign b        = ab_r[0];
  assign busy     = busy_r;
  assign overflow = overflow_r;

`ifdef QUADGEN_SWITCH_EN
  quadgen_switch #(
    .PRESS_CYCLES(PRESS_CYCLES)
  ) u_switch (
    .clk   (clk),
    .rst   (rst),
    .press (press),
    .sw    (sw)
  );
`else
  logic unused_press_s;
  assign unused_press_s = press ^ PRESS_CYCLES[0];
  assign sw = 1'b1;
`endif

endmodule

// File: doc/quadrature_generator.md
# quadrature_generator

Generates two-channel quadrature waveforms (A/B) plus an optional push-switch line from single-cycle up/down step commands, emulating a mechanical rotary encoder. It is the transmit-side counterpart of the rotary decoder: its outputs drive the decoder's `in_a`/`in_b`/`switch` inputs in simulation, self-test, and replay of recorded paddle motion. Requests are queued in a signed pending counter, so bursts of steps are emitted back-to-back at a fixed phase rate.

## Interface
- `DWELL`, default 4: clock cycles each quadrature phase is held; minimum 1.
- `PEND_W`, default 4: width of the signed pending-step counter; range ±(2^(PEND_W-1)-1).
- `PRESS_CYCLES`, default 16: cycles `sw` is held low per press.

- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `step_up` in 1: one-cycle request for one clockwise detent.
- `step_down` in 1: one-cycle request for one counter-clockwise detent.
- `press` in 1: one-cycle request for a switch press.
- `a` out 1: quadrature channel A, idle high.
- `b` out 1: quadrature channel B, idle high.
- `sw` out 1: switch line, active-low, idle high.
- `busy` out 1: high while the FSM is not IDLE or pending ≠ 0.
- `overflow` out 1: one-cycle pulse when a request is dropped because of saturation.

## Operation
- Reset values: `a`=1, `b`=1, `sw`=1, `busy`=0, `overflow`=0, pending=0, FSM=IDLE, dwell counter=0.
- Pending update each cycle: pending + `step_up` − `step_down` − consume.
  - consume is sign(pending) on every step start, otherwise 0.
  - If `step_up` and `step_down` arrive together, they cancel and no overflow is flagged.
- Saturation: a request that would push pending past ±max is dropped, pending is unchanged apart from consume, and `overflow` pulses for one cycle.
- FSM states: IDLE, PH1, PH2, PH3, PH4. Outputs (a,b) are registered per state.
  - Up sequence: PH1=(0,1), PH2=(0,0), PH3=(1,0), PH4=(1,1). B is high when A falls.
  - Down sequence: PH1=(1,0), PH2=(0,0), PH3=(0,1), PH4=(1,1). B is low when A falls.
- Transitions:
  - IDLE→PH1 when pending ≠ 0. Direction is latched from the sign of pending and the step is consumed.
  - PHn→PHn+1 after DWELL cycles in PHn.
  - PH4 after DWELL cycles: go to PH1 (new step, direction re-latched) if pending ≠ 0, otherwise go to IDLE.
- Reversal while a step is in flight: the current step completes in its latched direction; queued opposite requests are emitted afterwards.
- Switch path: on `press` while `sw`=1, drive `sw`=0 for exactly PRESS_CYCLES cycles. A `press` arriving while `sw`=0 is ignored. The switch path is independent of the quadrature FSM.
- Reset mid-step: `a`/`b` return to (1,1) on the reset edge. A truncated half-step is permitted; downstream logic tolerates it.

## Timing
- A request registered at edge E0 sets pending at E0. The FSM enters PH1 at E1, so the first output transition is visible after E1, one cycle after the request edge.
- One detent takes 4·DWELL cycles. Consecutive steps have no idle gap (PH4→PH1 directly).
- Sustained throughput: one step per 4·DWELL cycles.
- `overflow` asserts in the cycle after the offending request edge and lasts one cycle.
- A `press` at edge E0 drives `sw`=0 from E1 through E1+PRESS_CYCLES−1; `sw` returns to 1 at edge E1+PRESS_CYCLES.

## Configuration
- `QUADGEN_SWITCH_EN`:
  - Defined: the press timer is compiled in and `sw` behaves as described above.
  - Undefined: `sw` is tied to 1, `press` is ignored, and no timer logic is generated. The quadrature path is unaffected either way.

## Structure
- `quadgen_pkg` holds:
  - the state enum (IDLE, PH1..PH4);
  - the up and down phase-pattern constants (2-bit A/B per phase);
  - the idle level constant (2'b11).
- Sub-module `quadgen_switch` contains the press timer. It is instantiated only under `QUADGEN_SWITCH_EN`.
- The dwell counter and the pending counter stay inline in `quadrature_generator`.

## Test plan
- DWELL=2, single `step_up` → (a,b) = 01,00,10,11 with each phase lasting 2 cycles, then IDLE. A decoder model counts +1.
- DWELL=1, three `step_down` pulses in consecutive cycles → three contiguous down detents (12 cycles), no idle gap, decoder count −3, `busy` low afterwards.
- PEND_W=3, nine `step_up` pulses issued before the first step completes → pending saturates at 3 and `overflow` pulses on each dropped request. Exactly 4 detents are emitted in total: the one started immediately plus 3 queued.
- `step_up` and `step_down` in the same cycle while idle → no output change, pending stays 0, no overflow.
- `rst` asserted during PH2 → (a,b)=11, pending=0, `busy`=0 after the reset edge. A new `step_up` then produces one clean detent.
- `QUADGEN_SWITCH_EN` defined, PRESS_CYCLES=5, `press` pulsed twice 2 cycles apart → `sw` low for exactly 5 cycles and the second press is ignored. With the macro undefined, `sw` stays 1.
